md_unit: RTL and testbench
==========================

# md_unit

Iterative multiply/divide unit in the execute stage, beside the ALU. It takes the same two register-file operands as the ALU and executes MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results go into architectural HI/LO registers, which are read back via MFHI/MFLO through the result mux. A busy/done handshake lets the control unit stall the pipeline while an operation is in flight.

## Interface
- XLEN, 32, operand and HI/LO width; the only supported value is 32.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled on a rising edge only when busy=0
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are ignored
- a  in  32  operand rs (dividend / multiplicand / MTHI-MTLO source)
- b  in  32  operand rt (divisor / multiplier)
- busy  out  1  high while a mult/div is in progress
- done  out  1  one-cycle pulse when HI/LO have been updated by a mult/div
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Reset, asynchronous, whenever rst_n=0, from any state:
  - hi=0, lo=0, busy=0, done=0
  - state=IDLE; iteration counter=0
  - any operation in progress is discarded.
- States: IDLE, RUN, FIX.
- IDLE with start=1 and op=MTHI: hi<=a at that edge; lo unchanged, no busy, no done.
- IDLE with start=1 and op=MTLO: lo<=a at that edge; hi unchanged, no busy, no done.
- IDLE with start=1 and op a mult/div:
  - latch a, b and op
  - signed ops (MULT, DIV) convert both operands to magnitudes and record the sign flags
  - clear counter; go to RUN.
- IDLE with op 110/111: no action.
- RUN, 32 cycles:
  - multiply: shift-add, one multiplier bit per cycle, into a 64-bit product accumulator
  - divide: restoring, one quotient bit per cycle, with a 33-bit partial remainder
  - after the 32nd iteration, go to FIX.
- FIX, one cycle, writes hi/lo, asserts done and returns to IDLE:
  - multiply: negate the 64-bit product if sa^sb; hi=product[63:32], lo=product[31:0]
  - divide: lo=quotient, negated if sa^sb; hi=remainder, negated if sa (remainder takes the dividend's sign)
  - divide by zero, signed or unsigned: lo=32'hFFFF_FFFF, hi=original a (overrides the algorithm)
  - signed 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0; this falls out of the magnitude path with no special case.
- hi/lo hold their previous values for the whole RUN phase and change only at the FIX edge.
- Changes to a, b or op after the start edge have no effect.
- start while busy=1 is ignored, including MTHI/MTLO; the controller must hold the request until busy=0.

## Timing
- Call the edge that accepts start edge E0.
- busy rises after E0 and falls after E33: 33 cycles high.
- hi/lo update at E33; done=1 for exactly the cycle after E33.
- Total latency: 33 cycles from the accept edge to valid result; the next start can be accepted at E34.
- A start held high across E33 is not accepted at E33 (busy=1 is sampled there); it is accepted at E34.
- MTHI/MTLO: zero-latency register write at E0; new value is visible the cycle after E0.
- busy and done are registered outputs with no combinational path from start.
- rst_n deasserting mid-cycle leaves the unit in IDLE; the first edge with rst_n=1 can accept a start.

## Test plan
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> busy high 33 cycles; then hi=0xFFFF_FFFE, lo=0x0000_0001; done pulses once, in the cycle after E33.
- MULT a=0xFFFF_FFFD (-3), b=7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB (-21).
- DIV a=0xFFFF_FFF9 (-7), b=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); DIVU a=7, b=2 -> lo=3, hi=1.
- DIV a=0x8000_0000, b=0xFFFF_FFFF -> lo=0x8000_0000, hi=0; DIVU a=0x1234_5678, b=0 -> lo=0xFFFF_FFFF, hi=0x1234_5678.
- MTHI a=0xAAAA_0000, then MTLO a=0x5555 -> hi=0xAAAA_0000, lo=0x5555, busy never rises. Then start MULTU, and during RUN issue MTHI and change a/b -> all ignored; the product reflects the latched operands.
- hi=0x11, lo=0x22; start DIVU; pull rst_n low at iteration 10 -> busy, hi, lo and done read 0 immediately, done never pulses. After release, MULTU 3*5 -> lo=15, hi=0 at E33.

Source files
------------

// File: rtl/md_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with architectural HI/LO registers and MTHI/MTLO writes.
module md_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);
   localparam int CW = $clog2(XLEN);
   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]     cnt;
   logic              is_div, sa, sb, div0;
   logic [XLEN-1:0]   a_raw;
   logic [XLEN-1:0]   opnd;   // multiplicand for mul, divisor for div
   logic [2*XLEN-1:0] acc;    // product for mul; low half is the quotient for div
   logic [XLEN:0]     rem;

   logic              accept, sgn_op;
   logic [XLEN-1:0]   am, bm;
   logic [XLEN:0]     sum, rem_sh, diff;
   logic              ge;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quot, remd;

   assign accept = (state == IDLE) && start && !op[2];
   assign sgn_op = !op[0];
   assign am     = (sgn_op && a[XLEN-1]) ? -a : a;
   assign bm     = (sgn_op && b[XLEN-1]) ? -b : b;

   assign sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
   assign rem_sh = {rem[XLEN-1:0], acc[XLEN-1]};
   assign diff   = rem_sh - {1'b0, opnd};
   // rem < divisor always, so a negative trial difference shows up in the top bit
   assign ge     = !diff[XLEN];

   assign prod   = (sa ^ sb) ? -acc : acc;
   assign quot   = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
   assign remd   = sa ? -rem[XLEN-1:0] : rem[XLEN-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (cnt == CW'(XLEN-1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi     <= '0;
         lo     <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         cnt    <= '0;
         is_div <= 1'b0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         div0   <= 1'b0;
         a_raw  <= '0;
         opnd   <= '0;
         acc    <= '0;
         rem    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && op == OP_MTHI) hi <= a;
               if (start && op == OP_MTLO) lo <= a;
               if (accept) begin
                  is_div <= op[1];
                  sa     <= sgn_op & a[XLEN-1];
                  sb     <= sgn_op & b[XLEN-1];
                  div0   <= (b == '0);
                  a_raw  <= a;
                  opnd   <= op[1] ? bm : am;
                  acc    <= {{XLEN{1'b0}}, (op[1] ? am : bm)};
                  rem    <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (is_div) begin
                  rem           <= ge ? diff : rem_sh;
                  acc[XLEN-1:0] <= {acc[XLEN-2:0], ge};
               end else begin
                  acc <= {sum, acc[XLEN-1:1]};
               end
            end
            FIX: begin
               busy <= 1'b0;
               done <= 1'b1;
               if (!is_div) begin
                  hi <= prod[2*XLEN-1:XLEN];
                  lo <= prod[XLEN-1:0];
               end else if (div0) begin
                  hi <= a_raw;
                  lo <= '1;
               end else begin
                  hi <= remd;
                  lo <= quot;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_md_unit.sv
// Directed-vector bench for md_unit: latency, handshake, results, reset abort.
module tb_md_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_vec = 0;
   int n_err = 0;

   md_unit #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] v);
      @(negedge clk);
      start = 1'b1; op = o; a = v; b = 32'h0;
      @(posedge clk); #1;
      start = 1'b0; op = 3'b111;
   endtask

   // Issue one mult/div, watch busy/done/hi/lo for 40 cycles after the accept edge.
   task automatic md_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input bit disturb, input string tag);
      logic [31:0] hi0, lo0, rhi, rlo;
      int bcnt, dcnt, dpos;
      bit stable;
      @(negedge clk);
      hi0 = hi; lo0 = lo;
      start = 1'b1; op = o; a = av; b = bv;
      @(posedge clk); #1;
      start = 1'b0; op = 3'b111; a = $urandom; b = $urandom;
      bcnt = 0; dcnt = 0; dpos = -1; stable = 1'b1;
      rhi = 32'hx; rlo = 32'hx;
      for (int i = 0; i < 40; i++) begin
         if (busy) bcnt++;
         if (done) begin
            dcnt++;
            if (dpos < 0) begin dpos = i; rhi = hi; rlo = lo; end
         end else if (dcnt == 0 && (hi !== hi0 || lo !== lo0)) begin
            stable = 1'b0;
         end
         if (disturb && i == 5) begin
            start = 1'b1; op = 3'b100; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
         end
         if (disturb && i == 20) start = 1'b0;
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk({tag, " busy_cycles"}, 64'(bcnt), 64'd33);
      chk({tag, " done_pos"},    64'(dpos), 64'd33);
      chk({tag, " done_count"},  64'(dcnt), 64'd1);
      chk({tag, " hilo_hold"},   64'(stable), 64'd1);
      chk({tag, " hi"},          64'(rhi), 64'(ehi));
      chk({tag, " lo"},          64'(rlo), 64'(elo));
   endtask

   initial begin
      int dcnt;
      rst_n = 1'b0; start = 1'b0; op = 3'b111; a = '0; b = '0;
      #12;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst hi",   64'(hi),   64'd0);
      chk("rst lo",   64'(lo),   64'd0);
      @(negedge clk); rst_n = 1'b1;

      md_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
      md_op(3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg");
      md_op(3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg");
      md_op(3'b011, 32'd7,         32'd2,         32'd1,         32'd3,         1'b0, "divu");
      md_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, "div_ovf");
      md_op(3'b011, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b0, "divu_zero");
      md_op(3'b010, 32'h0000_0064, 32'h0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b0, "div_zero");

      // MTHI/MTLO write in zero latency and never raise busy
      mt(3'b100, 32'hAAAA_0000);
      chk("mthi hi",   64'(hi),   64'hAAAA_0000);
      chk("mthi busy", 64'(busy), 64'd0);
      mt(3'b101, 32'h0000_5555);
      chk("mtlo lo",   64'(lo),   64'h0000_5555);
      chk("mtlo hi",   64'(hi),   64'hAAAA_0000);
      chk("mtlo busy", 64'(busy), 64'd0);
      mt(3'b110, 32'h0BAD_0BAD);
      chk("op110 busy", 64'(busy), 64'd0);
      chk("op110 hi",   64'(hi),   64'hAAAA_0000);
      chk("op110 lo",   64'(lo),   64'h0000_5555);

      // MTHI and operand changes during RUN are ignored
      md_op(3'b001, 32'd6, 32'd7, 32'h0, 32'd42, 1'b1, "multu_disturb");

      // Reset in the middle of a divide discards it
      mt(3'b100, 32'h11);
      mt(3'b101, 32'h22);
      @(negedge clk);
      start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; op = 3'b111;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort done", 64'(done), 64'd0);
      chk("abort hi",   64'(hi),   64'd0);
      chk("abort lo",   64'(lo),   64'd0);
      @(negedge clk); rst_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) dcnt++;
      end
      chk("abort no_done", 64'(dcnt), 64'd0);
      md_op(3'b001, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, "multu_after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
